// File: rtl/palette_ram.sv
// Parametrised colour-table RAM: CPU register port with auto-increment,
// N registered video read channels, and a post-reset clear sequencer.
module palette_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9,
  parameter int N_VID  = 2
) (
  input  logic                      clock,
  input  logic                      reset_N,
  input  logic [1:0]                cpu_sel,
  input  logic                      cpu_wr,
  input  logic                      cpu_rd,
  input  logic [7:0]                cpu_wdata,
  output logic [7:0]                cpu_rdata,
  output logic                      cpu_rvalid,
  output logic                      cpu_ready,
  input  logic [N_VID*ADDR_W-1:0]   vid_addr,
  output logic [N_VID*DATA_W-1:0]   vid_data,
  output logic                      clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] SEL_ADDR_LO = 2'd0;
  localparam logic [1:0] SEL_ADDR_HI = 2'd1;
  localparam logic [1:0] SEL_DATA_LO = 2'd2;
  localparam logic [1:0] SEL_DATA_HI = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                    state_r;
  logic [ADDR_W-1:0]         clr_cnt_r;
  logic [ADDR_W-1:0]         addr_r;
  logic [7:0]                lo_latch_r;
  logic [7:0]                cpu_rdata_r;
  logic                      cpu_rvalid_r;
  logic                      cpu_ready_r;
  logic                      clr_busy_r;
  logic [N_VID*DATA_W-1:0]   vid_data_r;
  logic [DATA_W-1:0]         mem_r [DEPTH];

  logic                      cpu_ok_s;
  logic                      wr_s;
  logic                      rd_s;
  logic                      we_s;
  logic [ADDR_W-1:0]         waddr_s;
  logic [DATA_W-1:0]         wdata_s;
  logic [DATA_W-1:0]         cpu_word_s;
  logic [7:0]                cpu_hi_s;
  logic [15:0]               addr16_s;
  logic [ADDR_W-1:0]         addr_nx_s;
  logic [N_VID*DATA_W-1:0]   vid_word_s;

  // Write-first read: a write landing on the sampled address wins over the stored word.
  function automatic logic [DATA_W-1:0] fwd_read(
    input logic [ADDR_W-1:0] raddr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    if (we && (raddr == waddr)) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

  // CPU strobe qualification: accesses only count once the clear has finished.
  always_comb begin
    cpu_ok_s = (state_r == ST_IDLE) && reset_N;
    wr_s     = cpu_ok_s && cpu_wr;
    rd_s     = cpu_ok_s && cpu_rd && !cpu_wr;
  end

  // Single RAM write port shared by the clear sequencer and DATA_HI commits.
  always_comb begin
    we_s    = 1'b0;
    waddr_s = ADDR_ZERO;
    wdata_s = DATA_ZERO;
    if (!reset_N) begin
      we_s = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      we_s    = 1'b1;
      waddr_s = clr_cnt_r;
    end else if (wr_s && (cpu_sel == SEL_DATA_HI)) begin
      we_s    = 1'b1;
      waddr_s = addr_r;
      wdata_s = {cpu_wdata[DATA_W-9:0], lo_latch_r};
    end else begin
      we_s = 1'b0;
    end
  end

  // CPU-side read word and zero-extended views of the address register.
  always_comb begin
    cpu_word_s = fwd_read(addr_r, we_s, waddr_s, wdata_s, mem_r[addr_r]);
    cpu_hi_s   = 8'(cpu_word_s >> 8);
    addr16_s   = 16'(addr_r);
  end

  // Next address: byte loads from the CPU, or +1 after any DATA_HI access.
  always_comb begin
    addr_nx_s = addr_r;
    if (wr_s) begin
      case (cpu_sel)
        SEL_ADDR_LO: addr_nx_s = ADDR_W'({addr16_s[15:8], cpu_wdata});
        SEL_ADDR_HI: addr_nx_s = ADDR_W'({cpu_wdata, addr16_s[7:0]});
        SEL_DATA_HI: addr_nx_s = addr_r + ADDR_ONE;
        default:     addr_nx_s = addr_r;
      endcase
    end else if (rd_s && (cpu_sel == SEL_DATA_HI)) begin
      addr_nx_s = addr_r + ADDR_ONE;
    end else begin
      addr_nx_s = addr_r;
    end
  end

  // Per-channel video read words, each with its own forwarding compare.
  always_comb begin
    vid_word_s = {(N_VID*DATA_W){1'b0}};
    for (int k = 0; k < N_VID; k++) begin
      vid_word_s[k*DATA_W +: DATA_W] = fwd_read(vid_addr[k*ADDR_W +: ADDR_W], we_s, waddr_s,
                                                wdata_s, mem_r[vid_addr[k*ADDR_W +: ADDR_W]]);
    end
  end

  // Control FSM: clear sweep, CPU register file and registered CPU outputs.
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      state_r      <= ST_CLEAR;
      clr_cnt_r    <= ADDR_ZERO;
      clr_busy_r   <= 1'b1;
      cpu_ready_r  <= 1'b0;
      addr_r       <= ADDR_ZERO;
      lo_latch_r   <= 8'h00;
      cpu_rdata_r  <= 8'h00;
      cpu_rvalid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_cnt_r == ADDR_LAST) begin
            state_r     <= ST_IDLE;
            clr_busy_r  <= 1'b0;
            cpu_ready_r <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_r + ADDR_ONE;
          end
        end
        ST_IDLE: begin
          clr_busy_r  <= 1'b0;
          cpu_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_CLEAR;
          clr_cnt_r   <= ADDR_ZERO;
          clr_busy_r  <= 1'b1;
          cpu_ready_r <= 1'b0;
        end
      endcase

      addr_r <= addr_nx_s;
      if (wr_s && (cpu_sel == SEL_DATA_LO)) begin
        lo_latch_r <= cpu_wdata;
      end

      cpu_rvalid_r <= rd_s;
      if (rd_s) begin
        case (cpu_sel)
          SEL_ADDR_LO: cpu_rdata_r <= addr16_s[7:0];
          SEL_ADDR_HI: cpu_rdata_r <= addr16_s[15:8];
          SEL_DATA_LO: cpu_rdata_r <= cpu_word_s[7:0];
          SEL_DATA_HI: cpu_rdata_r <= cpu_hi_s;
          default:     cpu_rdata_r <= 8'h00;
        endcase
      end
    end
  end

  // RAM array; no reset, contents are zeroed by the clear sweep instead.
  always_ff @(posedge clock) begin
    if (we_s) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // Registered video outputs, one read per channel per cycle in every state.
  always_ff @(posedge clock) begin
    if (!reset_N) begin
      vid_data_r <= {(N_VID*DATA_W){1'b0}};
    end else begin
      vid_data_r <= vid_word_s;
    end
  end

  assign cpu_rdata  = cpu_rdata_r;
  assign cpu_rvalid = cpu_rvalid_r;
  assign cpu_ready  = cpu_ready_r;
  assign clr_busy   = clr_busy_r;
  assign vid_data   = vid_data_r;

endmodule

// File: tb/tb_palette_ram.sv
// Scoreboard bench for palette_ram: default instance plus an 8-bit-address,
// 16-bit-data, 4-channel instance sharing clock and reset.
module tb_palette_ram;

  logic        clock = 1'b0;
  logic        reset_N;

  logic [1:0]  a_sel, b_sel;
  logic        a_wr, a_rd, b_wr, b_rd;
  logic [7:0]  a_wdata, b_wdata, a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid, a_ready, b_ready, a_busy, b_busy;
  logic [17:0] a_vaddr, a_vdata;
  logic [31:0] b_vaddr;
  logic [63:0] b_vdata;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [7:0] exp_a, exp_b;

  always #5 clock = ~clock;

  palette_ram dut_a (
    .clock(clock), .reset_N(reset_N), .cpu_sel(a_sel), .cpu_wr(a_wr), .cpu_rd(a_rd),
    .cpu_wdata(a_wdata), .cpu_rdata(a_rdata), .cpu_rvalid(a_rvalid), .cpu_ready(a_ready),
    .vid_addr(a_vaddr), .vid_data(a_vdata), .clr_busy(a_busy)
  );

  palette_ram #(.ADDR_W(8), .DATA_W(16), .N_VID(4)) dut_b (
    .clock(clock), .reset_N(reset_N), .cpu_sel(b_sel), .cpu_wr(b_wr), .cpu_rd(b_rd),
    .cpu_wdata(b_wdata), .cpu_rdata(b_rdata), .cpu_rvalid(b_rvalid), .cpu_ready(b_ready),
    .vid_addr(b_vaddr), .vid_data(b_vdata), .clr_busy(b_busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input bit b, input logic [1:0] sel, input logic [7:0] d);
    if (b) begin b_sel = sel; b_wdata = d; b_wr = 1'b1; end
    else   begin a_sel = sel; a_wdata = d; a_wr = 1'b1; end
    tick();
    a_wr = 1'b0;
    b_wr = 1'b0;
  endtask

  task automatic cpu_read(input bit b, input logic [1:0] sel, input logic [7:0] exp);
    if (b) begin qb.push_back(exp); b_sel = sel; b_rd = 1'b1; end
    else   begin qa.push_back(exp); a_sel = sel; a_rd = 1'b1; end
    tick();
    a_rd = 1'b0;
    b_rd = 1'b0;
  endtask

  // Read strobe that must be ignored (no response expected).
  task automatic raw_read(input logic [1:0] sel);
    a_sel = sel;
    a_rd  = 1'b1;
    b_sel = sel;
    b_rd  = 1'b1;
    tick();
    a_rd = 1'b0;
    b_rd = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset_N = 1'b0;
    repeat (n) tick();
    reset_N = 1'b1;
  endtask

  // Count busy cycles after reset release on both instances, bounded.
  task automatic measure_clear(input string tag);
    int ca = 0;
    int cb = 0;
    int rdy_bad = 0;
    int guard = 0;
    while ((a_busy || b_busy) && guard < 2000) begin
      @(negedge clock);
      if (a_busy) ca++;
      if (b_busy) cb++;
      if (a_ready === a_busy) rdy_bad++;
      if (b_ready === b_busy) rdy_bad++;
      guard++;
    end
    chk({tag, "_clr_a"}, 64'(ca), 64'd512);
    chk({tag, "_clr_b"}, 64'(cb), 64'd256);
    chk({tag, "_ready"}, 64'(rdy_bad), 64'd0);
    @(posedge clock);
    #1;
  endtask

  // Monitor: every rvalid pulse pops one expected byte.
  always @(negedge clock) begin
    if (a_rvalid) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL a_rvalid_unexpected: got 1 expected 0");
      end else begin
        exp_a = qa.pop_front();
        chk("a_rdata", 64'(a_rdata), 64'(exp_a));
      end
    end
    if (b_rvalid) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL b_rvalid_unexpected: got 1 expected 0");
      end else begin
        exp_b = qb.pop_front();
        chk("b_rdata", 64'(b_rdata), 64'(exp_b));
      end
    end
  end

  initial begin
    reset_N = 1'b0;
    a_sel = 2'd0; a_wr = 1'b0; a_rd = 1'b0; a_wdata = 8'h00; a_vaddr = 18'h0;
    b_sel = 2'd0; b_wr = 1'b0; b_rd = 1'b0; b_wdata = 8'h00; b_vaddr = 32'h0;

    // Reset state
    tick();
    tick();
    chk("rst_rdata",  64'(a_rdata),  64'h0);
    chk("rst_rvalid", 64'(a_rvalid), 64'h0);
    chk("rst_vid_a",  64'(a_vdata),  64'h0);
    chk("rst_vid_b",  b_vdata,       64'h0);
    chk("rst_busy",   64'(a_busy),   64'h1);
    chk("rst_ready",  64'(a_ready),  64'h0);
    tick();
    reset_N = 1'b1;
    measure_clear("init");

    // Prefill every entry with 0x15A, then reset and verify full clear
    cpu_write(0, 2'd0, 8'h00);
    cpu_write(0, 2'd1, 8'h00);
    cpu_write(0, 2'd2, 8'h5A);
    repeat (512) cpu_write(0, 2'd3, 8'h01);
    a_vaddr = {9'h1FF, 9'h123};
    tick();
    chk("prefill_ch0", 64'(a_vdata[8:0]),  64'h15A);
    chk("prefill_ch1", 64'(a_vdata[17:9]), 64'h15A);
    do_reset(3);
    measure_clear("refill");
    for (int i = 0; i < 512; i++) begin
      a_vaddr = {9'(511 - i), 9'(i)};
      tick();
      chk("clear_ch0", 64'(a_vdata[8:0]),  64'h0);
      chk("clear_ch1", 64'(a_vdata[17:9]), 64'h0);
    end

    // Write, auto-increment and wrap
    cpu_write(0, 2'd0, 8'hFF);
    cpu_write(0, 2'd1, 8'h01);
    cpu_write(0, 2'd2, 8'hA5);
    cpu_write(0, 2'd3, 8'h01);
    cpu_write(0, 2'd3, 8'h01);
    a_vaddr = {9'h000, 9'h1FF};
    tick();
    chk("wrap_1ff", 64'(a_vdata[8:0]),  64'h1A5);
    chk("wrap_000", 64'(a_vdata[17:9]), 64'h1A5);
    cpu_read(0, 2'd0, 8'h01);
    cpu_read(0, 2'd1, 8'h00);

    // CPU read with auto-increment
    cpu_write(0, 2'd0, 8'h40);
    cpu_write(0, 2'd1, 8'h00);
    cpu_write(0, 2'd2, 8'h2C);
    cpu_write(0, 2'd3, 8'h01);
    cpu_write(0, 2'd0, 8'h40);
    cpu_read(0, 2'd2, 8'h2C);
    cpu_read(0, 2'd3, 8'h01);
    cpu_read(0, 2'd0, 8'h41);
    cpu_read(0, 2'd1, 8'h00);
    tick();

    // Forwarding: commit and two video reads of 0x010 at the same edge
    a_vaddr = {9'h011, 9'h012};
    cpu_write(0, 2'd0, 8'h10);
    cpu_write(0, 2'd1, 8'h00);
    cpu_write(0, 2'd2, 8'hF0);
    a_vaddr = {9'h010, 9'h010};
    cpu_write(0, 2'd3, 8'h00);
    chk("fwd_ch0", 64'(a_vdata[8:0]),  64'h0F0);
    chk("fwd_ch1", 64'(a_vdata[17:9]), 64'h0F0);

    // Reset at clr_cnt = 200 restarts the clear; strobes during clear ignored
    do_reset(1);
    repeat (100) tick();
    cpu_write(0, 2'd0, 8'h77);
    raw_read(2'd0);
    repeat (98) tick();
    do_reset(1);
    measure_clear("midclr");

    // Reset in the middle of a CPU write sequence
    cpu_write(0, 2'd0, 8'h33);
    cpu_write(0, 2'd1, 8'h01);
    cpu_write(0, 2'd2, 8'h99);
    do_reset(2);
    measure_clear("midwr");
    cpu_write(0, 2'd3, 8'h01);
    a_vaddr = {9'h133, 9'h000};
    tick();
    chk("midwr_e000", 64'(a_vdata[8:0]),  64'h100);
    chk("midwr_e133", 64'(a_vdata[17:9]), 64'h000);
    cpu_read(0, 2'd0, 8'h01);
    cpu_read(0, 2'd1, 8'h00);

    // Wide instance: 0xBEEF at 0xFF, all four channels reading it
    b_vaddr = {4{8'hFF}};
    cpu_write(1, 2'd0, 8'hFF);
    cpu_write(1, 2'd1, 8'h05);
    cpu_write(1, 2'd2, 8'hEF);
    cpu_write(1, 2'd3, 8'hBE);
    for (int k = 0; k < 4; k++) begin
      chk("b_fwd_ch", 64'(b_vdata[k*16 +: 16]), 64'hBEEF);
    end
    cpu_read(1, 2'd0, 8'h00);
    cpu_read(1, 2'd1, 8'h00);
    cpu_write(1, 2'd0, 8'hFF);
    cpu_read(1, 2'd2, 8'hEF);
    cpu_read(1, 2'd3, 8'hBE);
    cpu_read(1, 2'd0, 8'h00);

    repeat (3) tick();
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/palette_ram.md
# palette_ram

Parametrised colour-table RAM for the HuC6260 video colour encoder. It generalises the fixed 512×9 CRAM into a configurable depth and width with N independent video read channels. It adds a CPU-side register interface (address latch, split lo/hi data bytes, auto-increment) and a post-reset hardware clear sequencer. It sits between the CPU bus decoder and the pixel pipeline, which reads palette entries every dot clock.

## Interface
- ADDR_W, default 9: entry address width; depth DEPTH = 2**ADDR_W; legal range 8..12.
- DATA_W, default 9: entry width; legal range 9..16.
- N_VID, default 2: number of video read channels; legal range 1..4.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset_N  in  1  reset, synchronous, active-low.
- cpu_sel  in  2  register select: 0 = ADDR_LO, 1 = ADDR_HI, 2 = DATA_LO, 3 = DATA_HI.
- cpu_wr  in  1  single-cycle write strobe.
- cpu_rd  in  1  single-cycle read strobe; cpu_wr has priority if both are high.
- cpu_wdata  in  8  write byte.
- cpu_rdata  out  8  read byte, registered.
- cpu_rvalid  out  1  pulses high for one cycle with cpu_rdata.
- cpu_ready  out  1  high when CPU accesses are accepted; low during clear.
- vid_addr  in  N_VID*ADDR_W  packed per-channel read addresses; channel k occupies [k*ADDR_W +: ADDR_W].
- vid_data  out  N_VID*DATA_W  packed per-channel read data, registered.
- clr_busy  out  1  high while the clear sequencer runs.

## Operation
- **State machine: CLEAR → IDLE.**
  - Any cycle with reset_N = 0 forces CLEAR and clr_cnt = 0. This includes reset mid-clear, which restarts the clear from entry 0.
  - In CLEAR, each cycle writes 0 to entry clr_cnt, then clr_cnt increments.
  - When clr_cnt = DEPTH-1 is written, the next state is IDLE. IDLE is terminal until the next reset.
- **Reset values.**
  - cpu_rdata = 0, cpu_rvalid = 0, vid_data = 0, clr_busy = 1, cpu_ready = 0.
  - Address register = 0, lo-byte latch = 0.
- **CPU accesses during CLEAR.** cpu_wr and cpu_rd are ignored: no state change and no cpu_rvalid.
- **ADDR_LO write.** addr[7:0] ← cpu_wdata.
- **ADDR_HI write.** addr[ADDR_W-1:8] ← cpu_wdata[ADDR_W-9:0]. Upper bits are discarded.
- **DATA_LO write.** lo_latch ← cpu_wdata. No RAM write occurs.
- **DATA_HI write.**
  - Commits RAM[addr] ← {cpu_wdata[DATA_W-9:0], lo_latch}.
  - Then addr ← addr+1 modulo DEPTH (DEPTH-1 wraps to 0).
  - lo_latch is retained, so repeated DATA_HI writes reuse it.
- **Reads.**
  - DATA_LO read returns RAM[addr][7:0].
  - DATA_HI read returns {zero-padding, RAM[addr][DATA_W-1:8]}, then increments addr with the same wrap rule.
  - ADDR_LO and ADDR_HI reads return the current addr byte, zero-padded.
- **Video channels.**
  - Each cycle (any state), vid_data[k] ← RAM[vid_addr[k]]. Every channel is independent.
  - Any number of channels may read the same address.
- **Write-first forwarding.** If a RAM write (a CPU commit or a clear write) targets the same address that a video channel or CPU read samples in the same cycle, the read returns the newly written value.

## Timing
- Video read latency: 1 cycle. vid_addr presented at edge n appears on vid_data after edge n+1. Full throughput, one read per channel per cycle.
- CPU read: strobe at edge n → cpu_rdata valid and cpu_rvalid = 1 for the cycle following edge n+1. cpu_rvalid is otherwise 0.
- CPU write: RAM content is visible to any read sampled at the same edge as the commit (forwarding) and thereafter.
- Address increment takes effect at the strobe edge. A back-to-back strobe on the next cycle uses the incremented address.
- Clear duration:
  - clr_busy and !cpu_ready hold from the reset cycle through exactly DEPTH cycles after reset_N rises.
  - clr_busy falls and cpu_ready rises on the cycle after entry DEPTH-1 is written.
- cpu_ready = !clr_busy at all times.

## Test plan
- **Clear after reset.** Hold reset_N low 3 cycles with RAM pre-filled with nonzero data, release. Required: clr_busy stays high exactly 512 cycles (defaults), and every entry read on vid channels afterwards is 0.
- **Write, auto-increment and wrap.** With defaults: ADDR_LO = 0xFF, ADDR_HI = 0x01, DATA_LO = 0xA5, DATA_HI = 0x01 twice. Required: RAM[0x1FF] = 0x1A5, RAM[0x000] = 0x1A5, final addr = 0x001.
- **CPU read.** Store 0x12C at entry 0x040. Set addr to 0x040, read DATA_LO then DATA_HI. Required: cpu_rdata = 0x2C then 0x01, each with a one-cycle cpu_rvalid, and addr = 0x041 afterwards.
- **Forwarding.** Issue a DATA_HI write committing 0x0F0 to entry 0x010 while vid channel 0 and channel 1 both present address 0x010 at the same edge. Required: both vid_data outputs show 0x0F0 on the next cycle.
- **Reset mid-operation.** Assert reset_N low during clear at clr_cnt = 200, release. Required: clear restarts at 0 and clr_busy lasts a full 512 cycles. Repeat during a CPU write sequence: required addr = 0 and lo_latch = 0 after reset.
- **Parameter sweep.** ADDR_W = 8, DATA_W = 16, N_VID = 4: write 0xBEEF to entry 0xFF, with all four channels reading 0xFF. Required: 0xBEEF appears on all four channels, the clear lasts 256 cycles, and a DATA_HI read returns 0xBE.
